// File: rtl/note_scroll_buffer_if.sv
// Bus bundle for note_scroll_buffer: serial chart input, scroll control and row outputs.
// With NOTE_SCROLL_HIT_EN defined it also carries HIT_MASK, HIT and HIT_ANY.
interface note_scroll_buffer_if #(
    parameter int WIDTH  = 30,
    parameter int DEPTH  = 12,
    parameter int TAP_W  = $clog2(DEPTH),
    parameter int FILL_W = $clog2(DEPTH + 1)
);
    // Handshake: SHIFT_EN is a valid with no ready (the buffer takes DATA_IN on every
    // edge where SHIFT_EN=1); WORD_VALID is a one-cycle valid with no ready.
    logic              DATA_IN;
    logic              SHIFT_EN;
    logic              STEP;
    logic [TAP_W-1:0]  TAP_SEL;
    logic              BIT_OUT;
    logic              WORD_VALID;
    logic [WIDTH-1:0]  BYTE_OUT;
    logic [WIDTH-1:0]  TAP_OUT;
    logic              PENDING;
    logic              OVERRUN;
    logic              FULL;
    logic [FILL_W-1:0] FILL;
`ifdef NOTE_SCROLL_HIT_EN
    logic [WIDTH-1:0]  HIT_MASK;
    logic [WIDTH-1:0]  HIT;
    logic              HIT_ANY;

    modport master (
        output DATA_IN, SHIFT_EN, STEP, TAP_SEL, HIT_MASK,
        input  BIT_OUT, WORD_VALID, BYTE_OUT, TAP_OUT, PENDING, OVERRUN, FULL, FILL,
               HIT, HIT_ANY
    );
    modport slave (
        input  DATA_IN, SHIFT_EN, STEP, TAP_SEL, HIT_MASK,
        output BIT_OUT, WORD_VALID, BYTE_OUT, TAP_OUT, PENDING, OVERRUN, FULL, FILL,
               HIT, HIT_ANY
    );
`else
    modport master (
        output DATA_IN, SHIFT_EN, STEP, TAP_SEL,
        input  BIT_OUT, WORD_VALID, BYTE_OUT, TAP_OUT, PENDING, OVERRUN, FULL, FILL
    );
    modport slave (
        input  DATA_IN, SHIFT_EN, STEP, TAP_SEL,
        output BIT_OUT, WORD_VALID, BYTE_OUT, TAP_OUT, PENDING, OVERRUN, FULL, FILL
    );
`endif
endinterface

// File: rtl/note_scroll_buffer.sv
// Serial-to-row note buffer feeding a DEPTH-stage scroll delay line with a selectable tap.
// Optional strike-zone hit detection is enabled by defining NOTE_SCROLL_HIT_EN.
module note_scroll_buffer #(
    parameter int WIDTH  = 30,
    parameter int DEPTH  = 12,
    parameter int TAP_W  = $clog2(DEPTH),
    parameter int FILL_W = $clog2(DEPTH + 1)
) (
    input logic                 CLK,
    input logic                 RST,
    note_scroll_buffer_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    logic [WIDTH-1:0]  bit_reg_q, bit_reg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]  hold_q, hold_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic              word_valid_q, word_valid_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WIDTH-1:0]  tap_q, tap_d;
    logic [WIDTH-1:0]  stage_q [DEPTH];
    logic [WIDTH-1:0]  stage_d [DEPTH];
    logic              row_done;
    logic [WIDTH-1:0]  shifted;

    assign row_done = bus.SHIFT_EN && (bit_cnt_q == LAST_BIT);
    assign shifted  = {bit_reg_q[WIDTH-2:0], bus.DATA_IN};

    always_comb begin
        bit_reg_d    = bit_reg_q;
        bit_cnt_d    = bit_cnt_q;
        hold_d       = hold_q;
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        word_valid_d = 1'b0;
        fill_d       = fill_q;
        tap_d        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end

        if (bus.SHIFT_EN) begin
            bit_reg_d = shifted;
            bit_cnt_d = row_done ? '0 : bit_cnt_q + CNT_W'(1);
        end

        // STEP consumes the old hold contents before a same-edge completion reloads it.
        if (bus.STEP) begin
            stage_d[0] = pending_q ? hold_q : '0;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
            pending_d = 1'b0;
        end

        if (row_done) begin
            hold_d       = shifted;
            pending_d    = 1'b1;
            word_valid_d = 1'b1;
            if (pending_q && !bus.STEP) begin
                overrun_d = 1'b1;
            end
        end

        if (int'(bus.TAP_SEL) < DEPTH) begin
            tap_d = stage_q[bus.TAP_SEL];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_reg_q    <= '0;
            bit_cnt_q    <= '0;
            hold_q       <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            word_valid_q <= 1'b0;
            fill_q       <= '0;
            tap_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            bit_reg_q    <= bit_reg_d;
            bit_cnt_q    <= bit_cnt_d;
            hold_q       <= hold_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            word_valid_q <= word_valid_d;
            fill_q       <= fill_d;
            tap_q        <= tap_d;
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

`ifdef NOTE_SCROLL_HIT_EN
    logic [WIDTH-1:0] hit_q;
    logic             hit_any_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_q     <= '0;
            hit_any_q <= 1'b0;
        end else begin
            hit_q     <= stage_q[DEPTH-1] & bus.HIT_MASK;
            hit_any_q <= |(stage_q[DEPTH-1] & bus.HIT_MASK);
        end
    end

    assign bus.HIT     = hit_q;
    assign bus.HIT_ANY = hit_any_q;
`endif

    assign bus.BIT_OUT    = bit_reg_q[WIDTH-1];
    assign bus.WORD_VALID = word_valid_q;
    assign bus.BYTE_OUT   = stage_q[DEPTH-1];
    assign bus.TAP_OUT    = tap_q;
    assign bus.PENDING    = pending_q;
    assign bus.OVERRUN    = overrun_q;
    assign bus.FILL       = fill_q;
    assign bus.FULL       = (fill_q == FILL_MAX);
endmodule

// File: tb/tb_note_scroll_buffer.sv
// Bench for note_scroll_buffer (WIDTH=4, DEPTH=3): queue-based reference model,
// per-cycle expected snapshots checked by a negedge monitor, plus spec-value spot checks.
module tb_note_scroll_buffer;
    localparam int W  = 4;
    localparam int D  = 3;
    localparam int FW = $clog2(D + 1);

    typedef struct {
        logic          bit_o;
        logic          wv;
        logic [W-1:0]  byte_o;
        logic [W-1:0]  tap;
        logic          pend;
        logic          ovr;
        logic          full;
        logic [FW-1:0] fill;
        logic [W-1:0]  hit;
        logic          hit_any;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [W-1:0] hm = '0;
    exp_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [W-1:0] line[$];
    logic [W-1:0] m_bits, m_hold, m_tap, m_hit;
    int           m_cnt, m_fill;
    logic         m_pend, m_ovr, m_wv;

    note_scroll_buffer_if #(.WIDTH(W), .DEPTH(D)) bus ();
    note_scroll_buffer #(.WIDTH(W), .DEPTH(D)) dut (.CLK(clk), .RST(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic sh, input logic d, input logic st,
                              input logic [1:0] sel);
        exp_t e;
        logic done;
        logic [W-1:0] nb;
        if (r) begin
            m_bits = '0; m_cnt = 0; m_hold = '0; m_pend = 0; m_ovr = 0; m_wv = 0;
            m_fill = 0; m_tap = '0; m_hit = '0;
            line = {};
            repeat (D) line.push_back('0);
        end else begin
            m_tap = (int'(sel) < D) ? line[sel] : '0;
            m_hit = line[D-1] & hm;
            done  = sh && (m_cnt == W - 1);
            nb    = {m_bits[W-2:0], d};
            if (st) begin
                line.push_front(m_pend ? m_hold : '0);
                void'(line.pop_back());
                if (m_fill < D) m_fill++;
            end
            if (done && m_pend && !st) m_ovr = 1'b1;
            if (st) m_pend = 1'b0;
            if (done) begin
                m_hold = nb;
                m_pend = 1'b1;
            end
            m_wv = done;
            if (sh) begin
                m_bits = nb;
                m_cnt  = (m_cnt + 1) % W;
            end
        end
        e.bit_o   = m_bits[W-1];
        e.wv      = m_wv;
        e.byte_o  = line[D-1];
        e.tap     = m_tap;
        e.pend    = m_pend;
        e.ovr     = m_ovr;
        e.fill    = FW'(m_fill);
        e.full    = (m_fill == D);
        e.hit     = m_hit;
        e.hit_any = |m_hit;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic sh, input logic d, input logic st,
                         input logic [1:0] sel);
        rst          = r;
        bus.SHIFT_EN = sh;
        bus.DATA_IN  = d;
        bus.STEP     = st;
        bus.TAP_SEL  = sel;
`ifdef NOTE_SCROLL_HIT_EN
        bus.HIT_MASK = hm;
`endif
        model_step(r, sh, d, st, sel);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] sel);
        drive(1'b0, 1'b0, 1'b0, 1'b0, sel);
    endtask

    task automatic step_only();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    endtask

    task automatic shift_row(input logic [W-1:0] row, input logic last_step);
        for (int i = W - 1; i >= 0; i--) begin
            drive(1'b0, 1'b1, row[i], (i == 0) ? last_step : 1'b0, 2'd0);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp("bit_out",    32'(bus.BIT_OUT),    32'(e.bit_o));
            cmp("word_valid", 32'(bus.WORD_VALID), 32'(e.wv));
            cmp("byte_out",   32'(bus.BYTE_OUT),   32'(e.byte_o));
            cmp("tap_out",    32'(bus.TAP_OUT),    32'(e.tap));
            cmp("pending",    32'(bus.PENDING),    32'(e.pend));
            cmp("overrun",    32'(bus.OVERRUN),    32'(e.ovr));
            cmp("full",       32'(bus.FULL),       32'(e.full));
            cmp("fill",       32'(bus.FILL),       32'(e.fill));
`ifdef NOTE_SCROLL_HIT_EN
            cmp("hit",        32'(bus.HIT),        32'(e.hit));
            cmp("hit_any",    32'(bus.HIT_ANY),    32'(e.hit_any));
`endif
        end
    end

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // reset from arbitrary state
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
        cmp("rst_byte",    32'(bus.BYTE_OUT), 32'd0);
        cmp("rst_tap",     32'(bus.TAP_OUT),  32'd0);
        cmp("rst_fill",    32'(bus.FILL),     32'd0);
        cmp("rst_full",    32'(bus.FULL),     32'd0);
        cmp("rst_pending", 32'(bus.PENDING),  32'd0);
        cmp("rst_overrun", 32'(bus.OVERRUN),  32'd0);
        cmp("rst_bit",     32'(bus.BIT_OUT),  32'd0);

        // row assembly
        shift_row(4'b1011, 1'b0);
        cmp("row_wv",      32'(bus.WORD_VALID), 32'd1);
        cmp("row_pending", 32'(bus.PENDING),    32'd1);
        step_only();
        cmp("row_wv_drop", 32'(bus.WORD_VALID), 32'd0);
        cmp("row_consumed", 32'(bus.PENDING),   32'd0);
        step_only();
        cmp("row_empty_out", 32'(bus.BYTE_OUT), 32'd0);
        step_only();
        cmp("row_out",     32'(bus.BYTE_OUT),   32'hB);

        // completion on the same edge as STEP
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        shift_row(4'b1100, 1'b0);
        shift_row(4'b0011, 1'b1);
        cmp("sim_pending", 32'(bus.PENDING), 32'd1);
        cmp("sim_overrun", 32'(bus.OVERRUN), 32'd0);
        idle(2'd0);
        cmp("sim_stage0",  32'(bus.TAP_OUT), 32'hC);
        step_only();
        idle(2'd0);
        cmp("sim_hold",    32'(bus.TAP_OUT), 32'h3);

        // overrun
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        shift_row(4'b0001, 1'b0);
        shift_row(4'b0010, 1'b0);
        cmp("ovr_set",     32'(bus.OVERRUN), 32'd1);
        step_only();
        idle(2'd0);
        cmp("ovr_loaded",  32'(bus.TAP_OUT), 32'h2);
        cmp("ovr_sticky",  32'(bus.OVERRUN), 32'd1);

        // tap, fill, reset
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        shift_row(4'b0001, 1'b0); step_only();
        shift_row(4'b0010, 1'b0); step_only();
        cmp("fill_2_notfull", 32'(bus.FULL), 32'd0);
        shift_row(4'b0100, 1'b0); step_only();
        cmp("full_set",    32'(bus.FULL), 32'd1);
        cmp("fill_3",      32'(bus.FILL), 32'd3);
        idle(2'd1);
        cmp("tap_1",       32'(bus.TAP_OUT), 32'h2);
        idle(2'd3);
        cmp("tap_oob",     32'(bus.TAP_OUT), 32'h0);
        step_only();
        cmp("fill_sat",    32'(bus.FILL), 32'd3);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        cmp("fill_rst",    32'(bus.FILL), 32'd0);
        cmp("full_rst",    32'(bus.FULL), 32'd0);

`ifdef NOTE_SCROLL_HIT_EN
        shift_row(4'b0110, 1'b0);
        step_only(); step_only(); step_only();
        hm = 4'b0100;
        idle(2'd0);
        cmp("hit_one",     32'(bus.HIT),     32'h4);
        cmp("hit_any_one", 32'(bus.HIT_ANY), 32'd1);
        hm = 4'b1001;
        idle(2'd0);
        cmp("hit_none",     32'(bus.HIT),     32'h0);
        cmp("hit_any_none", 32'(bus.HIT_ANY), 32'd0);
`endif

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            hm = 4'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  2'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
